// File: rtl/fetch_pc_ctrl.sv
// Purpose  : fetch-stage PC controller; owns the fetch PC, drives the imem request and IF/ID valid/flush.
// Latency  : a fetch completes in the imem_ready cycle; a redirect lands on the next PC-advance edge.
// Backpres.: imem_req/imem_addr are held until imem_ready; stall parks a completed word in HOLD.
//
// Ports:
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_stall             hazard hold of PC and IF/ID
//   i_is_branch         taken branch/jump/trap redirect, target on i_branch_target
//   i_exception         exception redirect to EXC_VECTOR (beats i_is_branch)
//   i_imem_ready        instruction memory returns data this cycle
//   o_imem_req          fetch request, o_imem_addr always equals o_pc
//   o_if_valid          fetched word valid for IF/ID this cycle
//   o_flush_if          squash the IF/ID entry
//
// Build option: define BRANCH_DELAY_SLOT_EN for MIPS delay-slot branch semantics.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_is_branch,
    input  logic [31:0] i_branch_target,
    input  logic        i_exception,
    input  logic        i_imem_ready,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_pc,
    output logic        o_if_valid,
    output logic        o_flush_if
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic DS_EN = 1'b1;
`else
    localparam logic DS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic        r_pend_vld;
    logic        r_pend_exc;
    logic [31:0] r_pend_tgt;

    logic        w_fetching;
    logic        w_adv;
    logic        w_br_direct;
    logic        w_pend_squash;
    logic        w_squash;
    logic        w_pend_exc_held;
    logic        w_br_latch;
    logic [31:0] w_pc_nxt;

    assign w_fetching = (r_state == S_REQ) || (r_state == S_WAIT);

    // PC advance point: a fetch completes (or a held word is released) with no stall.
    assign w_adv = !i_rst && !i_stall && ((w_fetching && i_imem_ready) || (r_state == S_HOLD));

    // Without delay slots a branch at the advance point redirects immediately;
    // with delay slots it always goes through the pending register first.
    assign w_br_direct   = !DS_EN && i_is_branch;
    // A pending delay-slot branch lets the slot word through; anything else squashes it.
    assign w_pend_squash = r_pend_vld && (r_pend_exc || !DS_EN);
    assign w_squash      = i_exception || w_pend_squash || w_br_direct;

    always_comb begin
        w_pc_nxt = r_pc + 32'd4;
        if (i_exception) begin
            w_pc_nxt = EXC_VECTOR;
        end else if (r_pend_vld) begin
            w_pc_nxt = r_pend_tgt;
        end else if (w_br_direct) begin
            w_pc_nxt = i_branch_target;
        end
    end

    // A pending exception is never displaced by a branch; at an advance point the
    // pending entry wins over a new branch, except for a delay-slot branch that
    // needs to queue behind the slot word.
    assign w_pend_exc_held = r_pend_vld && r_pend_exc;
    assign w_br_latch = i_is_branch && !i_exception && !w_pend_exc_held && (!w_adv || DS_EN);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ, S_WAIT: begin
                if (i_imem_ready) begin
                    w_state_nxt = i_stall ? S_HOLD : S_REQ;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_HOLD: begin
                if (!i_stall) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // Output logic; everything is quiet during the reset cycle.
    always_comb begin
        o_imem_req  = !i_rst && w_fetching;
        o_imem_addr = r_pc;
        o_pc        = r_pc;
        o_if_valid  = w_adv && !w_squash;
        o_flush_if  = w_adv && w_squash;
    end

    // Fetch PC and pending redirect.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_pend_vld <= 1'b0;
            r_pend_exc <= 1'b0;
            r_pend_tgt <= 32'd0;
        end else begin
            if (w_adv) begin
                r_pc       <= w_pc_nxt;
                r_pend_vld <= 1'b0;
                r_pend_exc <= 1'b0;
            end
            if (i_exception && !w_adv) begin
                r_pend_vld <= 1'b1;
                r_pend_exc <= 1'b1;
                r_pend_tgt <= EXC_VECTOR;
            end else if (w_br_latch) begin
                r_pend_vld <= 1'b1;
                r_pend_exc <= 1'b0;
                r_pend_tgt <= i_branch_target;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Purpose  : directed self-checking bench for fetch_pc_ctrl with a scoreboard queue.
// Latency  : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpres.: imem_ready and stall are driven directly by the step sequence.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        is_branch;
    logic [31:0] branch_target;
    logic        exception;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic        if_valid;
    logic        flush_if;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic        vld;
        logic        fl;
    } obs_t;

    obs_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall        (stall),
        .i_is_branch    (is_branch),
        .i_branch_target(branch_target),
        .i_exception    (exception),
        .i_imem_ready   (imem_ready),
        .o_imem_req     (imem_req),
        .o_imem_addr    (imem_addr),
        .o_pc           (pc),
        .o_if_valid     (if_valid),
        .o_flush_if     (flush_if)
    );

    // One clock cycle: drive inputs, queue the expected outputs, compare on the falling edge.
    task automatic cyc(input logic r_i, input logic st_i, input logic br_i, input logic [31:0] tgt_i,
                       input logic ex_i, input logic rdy_i, input logic chk,
                       input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                       input logic e_fl, input string tag);
        obs_t ex;
        obs_t ob;
        rst           = r_i;
        stall         = st_i;
        is_branch     = br_i;
        branch_target = tgt_i;
        exception     = ex_i;
        imem_ready    = rdy_i;
        if (chk) sb_q.push_back('{e_req, e_addr, e_addr, e_vld, e_fl});
        @(negedge clk);
        if (chk) begin
            ex = sb_q.pop_front();
            ob = '{imem_req, imem_addr, pc, if_valid, flush_if};
            n_vec++;
            assert (ob === ex) else begin
                n_err++;
                $error("FAIL %s: observed req=%0b addr=%h pc=%h vld=%0b flush=%0b, expected req=%0b addr=%h pc=%h vld=%0b flush=%0b",
                       tag, ob.req, ob.addr, ob.pc, ob.vld, ob.fl, ex.req, ex.addr, ex.pc, ex.vld, ex.fl);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        cyc(1, 0, 0, 32'd0, 0, 1, 0, 0, 32'd0, 0, 0, tag);
        cyc(1, 0, 0, 32'd0, 0, 1, 1, 0, 32'h0040_0000, 0, 0, tag);
    endtask

    initial begin
        @(posedge clk);
        #1;
        //   rst st br target        ex rdy chk req addr           vld fl
        do_reset("reset");

        // Sequential fetch with imem_ready tied high.
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0000, 1, 0, "seq0");
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0004, 1, 0, "seq1");
`ifdef BRANCH_DELAY_SLOT_EN
        cyc(0, 0, 1, 32'h0040_0100,  0, 1,  1,  1, 32'h0040_0008, 1, 0, "br_ds_slot");
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_000C, 1, 0, "br_ds_next");
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0100, 1, 0, "br_ds_target");
`else
        cyc(0, 0, 1, 32'h0040_0100,  0, 1,  1,  1, 32'h0040_0008, 0, 1, "br_flush");
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0100, 1, 0, "br_target");
`endif

        // Branch during an outstanding fetch: address holds, pending redirect applied at completion.
        do_reset("reset_wait");
        cyc(0, 0, 1, 32'h0040_0200,  0, 0,  1,  1, 32'h0040_0000, 0, 0, "wait_br");
        cyc(0, 0, 0, 32'd0,          0, 0,  1,  1, 32'h0040_0000, 0, 0, "wait_hold1");
        cyc(0, 0, 0, 32'd0,          0, 0,  1,  1, 32'h0040_0000, 0, 0, "wait_hold2");
`ifdef BRANCH_DELAY_SLOT_EN
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0000, 1, 0, "wait_done");
`else
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0000, 0, 1, "wait_done");
`endif
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0200, 1, 0, "wait_target");

        // Stall with simultaneous branch and exception: exception wins after the stall.
        do_reset("reset_stall");
        cyc(0, 1, 1, 32'h0040_0300,  1, 1,  1,  1, 32'h0040_0000, 0, 0, "stall_in");
        cyc(0, 1, 0, 32'd0,          0, 1,  1,  0, 32'h0040_0000, 0, 0, "stall_hold");
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  0, 32'h0040_0000, 0, 1, "stall_release");
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0004, 1, 0, "exc_vector");
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0008, 1, 0, "exc_next");

        // PC wrap at the top of the address space.
        do_reset("reset_wrap");
`ifdef BRANCH_DELAY_SLOT_EN
        cyc(0, 0, 1, 32'hFFFF_FFFC,  0, 1,  1,  1, 32'h0040_0000, 1, 0, "wrap_br");
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0004, 1, 0, "wrap_slot");
`else
        cyc(0, 0, 1, 32'hFFFF_FFFC,  0, 1,  1,  1, 32'h0040_0000, 0, 1, "wrap_br");
`endif
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'hFFFF_FFFC, 1, 0, "wrap_top");
        cyc(0, 0, 0, 32'd0,          0, 0,  1,  1, 32'h0000_0000, 0, 0, "wrap_zero");

        // Reset while waiting on imem: the late ready is ignored, fetch restarts at RESET_PC.
        cyc(0, 0, 0, 32'd0,          0, 0,  1,  1, 32'h0000_0000, 0, 0, "rst_wait");
        cyc(1, 0, 0, 32'd0,          0, 1,  1,  0, 32'h0000_0000, 0, 0, "rst_late_rdy");
        cyc(0, 0, 0, 32'd0,          0, 0,  1,  1, 32'h0040_0000, 0, 0, "rst_restart");
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0000, 1, 0, "rst_fetch");
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0004, 1, 0, "rst_next");

        // Immediate exception with no stall squashes the in-flight word.
        cyc(0, 0, 0, 32'd0,          1, 1,  1,  1, 32'h0040_0008, 0, 1, "exc_now");
        cyc(0, 0, 0, 32'd0,          0, 1,  1,  1, 32'h0040_0004, 1, 0, "exc_now_vec");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
